attractor_sweep: RTL and testbench



---
 rtl/gene_pkg.sv | 22 ++
 rtl/visit_table.sv | 46 ++++
 rtl/attractor_sweep.sv | 121 ++++++++++++
 tb/tb_attractor_sweep.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gene_pkg.sv
// Shared definitions for the attractor sweep block.
//   STATE_W / STEP_W : widths of a gene_net state and of the step counter
//   FIXED / CYCLE    : res_type encodings
//   state_e          : sweep controller FSM states
package gene_pkg;

   localparam int unsigned STATE_W = 8;
   localparam int unsigned STEP_W  = 9;

   localparam logic FIXED = 1'b0;
   localparam logic CYCLE = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSettle,
      StTrack,
      StReport,
      StFinish
   } state_e;

endpackage

// File: rtl/visit_table.sv
// Visited-state table for one trajectory: a 256-bit visited vector plus the step
// index at which each state was first seen.
//   clk, rst_n : clock, asynchronous active-low reset (clears visited vector)
//   i_clear    : clear every visited bit in one cycle
//   i_wr_en    : mark i_addr visited and store i_wr_idx as its index
//   i_addr     : state being looked up / written
//   i_wr_idx   : step number to record
//   o_visited  : i_addr has been visited since the last clear
//   o_idx      : step at which i_addr was first visited (valid when o_visited)
module visit_table
   import gene_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_clear,
   input  logic               i_wr_en,
   input  logic [STATE_W-1:0] i_addr,
   input  logic [STEP_W-1:0]  i_wr_idx,
   output logic               o_visited,
   output logic [STEP_W-1:0]  o_idx
);

   logic [255:0]      r_visited;
   logic [STEP_W-1:0] r_idx [256];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_visited <= '0;
      end else if (i_clear) begin
         r_visited <= '0;
      end else if (i_wr_en) begin
         r_visited[i_addr] <= 1'b1;
      end
   end

   // Index entries are only read behind a set visited bit, so no clear is needed.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_idx[i_addr] <= i_wr_idx;
      end
   end

   assign o_visited = r_visited[i_addr];
   assign o_idx     = r_idx[i_addr];

endmodule

// File: rtl/attractor_sweep.sv
// Sweeps gene_net initial values FIRST_VAL..LAST_VAL, follows each trajectory until
// a state repeats and reports the attractor (entry state, length, transient).
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begins a sweep when idle
//   init_val, load      : initial value and load pulse towards gene_net
//   x                   : current gene_net state
//   res_valid/res_ready : result record handshake
//   res_init/type/state/len/trans : result record fields
//   busy, done          : sweep in progress, one-cycle end-of-sweep pulse
module attractor_sweep
   import gene_pkg::*;
#(
   parameter logic [STATE_W-1:0] FIRST_VAL = 8'h00,
   parameter logic [STATE_W-1:0] LAST_VAL  = 8'hFF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [STATE_W-1:0] init_val,
   output logic               load,
   input  logic [STATE_W-1:0] x,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [STATE_W-1:0] res_init,
   output logic               res_type,
   output logic [STATE_W-1:0] res_state,
   output logic [STEP_W-1:0]  res_len,
   output logic [STEP_W-1:0]  res_trans,
   output logic               busy,
   output logic               done
);

   state_e             r_state, w_state_nxt;
   logic [STATE_W-1:0] r_cur;
   logic [STEP_W-1:0]  r_step;
   logic [STATE_W-1:0] r_res_init, r_res_state;
   logic               r_res_type;
   logic [STEP_W-1:0]  r_res_len, r_res_trans;

   logic               w_clear, w_wr_en, w_visited, w_hs;
   logic [STEP_W-1:0]  w_idx, w_len;

   visit_table u_visit_table (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_clear),
      .i_wr_en   (w_wr_en),
      .i_addr    (x),
      .i_wr_idx  (r_step),
      .o_visited (w_visited),
      .o_idx     (w_idx)
   );

   assign w_len = r_step - w_idx;
   assign w_hs  = (r_state == StReport) && res_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_wr_en     = 1'b0;
      unique case (r_state)
         StIdle:   if (start) w_state_nxt = StLoad;
         StLoad: begin
            w_clear     = 1'b1;
            w_state_nxt = StSettle;
         end
         StSettle: w_state_nxt = StTrack;
         StTrack: begin
            if (w_visited) w_state_nxt = StReport;
            else           w_wr_en     = 1'b1;
         end
         StReport: begin
            if (res_ready) w_state_nxt = (r_cur == LAST_VAL) ? StFinish : StLoad;
         end
         StFinish: w_state_nxt = StIdle;
         default:  w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_cur       <= '0;
         r_step      <= '0;
         r_res_init  <= '0;
         r_res_type  <= FIXED;
         r_res_state <= '0;
         r_res_len   <= '0;
         r_res_trans <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == StIdle && start) r_cur <= FIRST_VAL;
         // Guard keeps cur from wrapping past 8'hFF when LAST_VAL is the top value.
         if (w_hs && r_cur != LAST_VAL)  r_cur <= r_cur + 8'd1;
         if (r_state == StLoad)          r_step <= '0;
         // At most 256 distinct states, so step peaks at 256 and never wraps.
         if (w_wr_en)                    r_step <= r_step + 9'd1;
         if (r_state == StTrack && w_visited) begin
            r_res_init  <= r_cur;
            r_res_state <= x;
            r_res_len   <= w_len;
            r_res_trans <= w_idx;
            r_res_type  <= (w_len != 9'd1) ? CYCLE : FIXED;
         end
      end
   end

   // cur only changes on the way into LOAD, so it doubles as the held init value.
   assign init_val  = r_cur;
   assign load      = (r_state == StLoad);
   assign res_valid = (r_state == StReport);
   assign res_init  = r_res_init;
   assign res_type  = r_res_type;
   assign res_state = r_res_state;
   assign res_len   = r_res_len;
   assign res_trans = r_res_trans;
   assign busy      = (r_state == StLoad) || (r_state == StSettle) ||
                      (r_state == StTrack) || (r_state == StReport);
   assign done      = (r_state == StFinish);

endmodule

// File: tb/tb_attractor_sweep.sv
// Scoreboard bench for attractor_sweep: stimulus pushes expected records, monitors
// pop and compare on each res_valid && res_ready handshake.
module tb_attractor_sweep;

   typedef struct packed {
      logic [7:0] init;
      logic       typ;
      logic [7:0] state;
      logic [8:0] len;
      logic [8:0] trans;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // 0: identity (fixed points), 1: increment, 2: x>=8 -> x-4, else 4+((x+1)%4)
   logic [1:0] map_sel;
   function automatic logic [7:0] gene_f(input logic [1:0] sel, input logic [7:0] v);
      case (sel)
         2'd0:    return v;
         2'd1:    return v + 8'd1;
         default: return (v >= 8'd8) ? v - 8'd4 : 8'd4 + {6'd0, v[1:0] + 2'd1};
      endcase
   endfunction

   // ---------------- DUT A: default sweep 00..FF ----------------
   logic       start_a, load_a, vld_a, rdy_a, rtype_a, busy_a, done_a;
   logic [7:0] init_a, x_a, rinit_a, rstate_a;
   logic [8:0] rlen_a, rtrans_a;

   attractor_sweep u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_a),
      .init_val  (init_a),
      .load      (load_a),
      .x         (x_a),
      .res_valid (vld_a),
      .res_ready (rdy_a),
      .res_init  (rinit_a),
      .res_type  (rtype_a),
      .res_state (rstate_a),
      .res_len   (rlen_a),
      .res_trans (rtrans_a),
      .busy      (busy_a),
      .done      (done_a)
   );

   // gene_net stub: loads on load, holds one extra cycle, then steps each cycle
   logic a_hold;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_a    <= '0;
         a_hold <= 1'b0;
      end else if (load_a) begin
         x_a    <= init_a;
         a_hold <= 1'b1;
      end else if (a_hold) begin
         a_hold <= 1'b0;
      end else begin
         x_a <= gene_f(map_sel, x_a);
      end
   end

   // ---------------- DUT 5: single init 05 ----------------
   logic       start_5, load_5, vld_5, rdy_5, rtype_5, busy_5, done_5;
   logic [7:0] init_5, x_5, rinit_5, rstate_5;
   logic [8:0] rlen_5, rtrans_5;

   attractor_sweep #(
      .FIRST_VAL (8'h05),
      .LAST_VAL  (8'h05)
   ) u_dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_5),
      .init_val  (init_5),
      .load      (load_5),
      .x         (x_5),
      .res_valid (vld_5),
      .res_ready (rdy_5),
      .res_init  (rinit_5),
      .res_type  (rtype_5),
      .res_state (rstate_5),
      .res_len   (rlen_5),
      .res_trans (rtrans_5),
      .busy      (busy_5),
      .done      (done_5)
   );

   logic h5;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_5 <= '0;
         h5  <= 1'b0;
      end else if (load_5) begin
         x_5 <= init_5;
         h5  <= 1'b1;
      end else if (h5) begin
         h5 <= 1'b0;
      end else begin
         x_5 <= gene_f(2'd0, x_5);
      end
   end

   // ---------------- scoreboards / monitors ----------------
   rec_t exp_a[$];
   rec_t exp_5[$];
   rec_t cur_a, last_a, e_a, cur_5, e_5;
   bit   stalled_a = 1'b0;
   int   hs_a = 0, done_cnt_a = 0, done_cnt_5 = 0;

   always @(negedge clk) begin
      cur_a = '{rinit_a, rtype_a, rstate_a, rlen_a, rtrans_a};
      if (rst_n && vld_a) begin
         if (stalled_a) chk("stable_a", cur_a, last_a);
         if (rdy_a) begin
            if (exp_a.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rec_a: unexpected record %0h", cur_a);
            end else begin
               e_a = exp_a.pop_front();
               chk("rec_a", cur_a, e_a);
            end
            hs_a++;
            stalled_a = 1'b0;
         end else begin
            stalled_a = 1'b1;
            last_a    = cur_a;
         end
      end else begin
         stalled_a = 1'b0;
      end
      if (rst_n && done_a) begin
         done_cnt_a++;
         chk("busy_at_done_a", busy_a, 0);
      end
   end

   always @(negedge clk) begin
      cur_5 = '{rinit_5, rtype_5, rstate_5, rlen_5, rtrans_5};
      if (rst_n && vld_5 && rdy_5) begin
         if (exp_5.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rec_5: unexpected record %0h", cur_5);
         end else begin
            e_5 = exp_5.pop_front();
            chk("rec_5", cur_5, e_5);
         end
      end
      if (rst_n && done_5) done_cnt_5++;
   end

   task automatic pulse_a();
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   int hs_base;

   initial begin
      rst_n   = 1'b0;
      start_a = 1'b0;
      start_5 = 1'b0;
      rdy_a   = 1'b1;
      rdy_5   = 1'b1;
      map_sel = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_a", {init_a, load_a, vld_a, rinit_a, rtype_a, rstate_a, rlen_a, rtrans_a,
                      busy_a, done_a}, 64'd0);
      chk("reset_5", {init_5, load_5, vld_5, rinit_5, rtype_5, rstate_5, rlen_5, rtrans_5,
                      busy_5, done_5}, 64'd0);
      @(negedge clk) rst_n = 1'b1;

      // Single-init sweep, fixed point at 05
      exp_5.push_back(rec_t'{8'h05, 1'b0, 8'h05, 9'd1, 9'd0});
      @(posedge clk); #1 start_5 = 1'b1;
      @(posedge clk); #1 start_5 = 1'b0;
      for (int i = 0; i < 100 && done_cnt_5 == 0; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      chk("done_5_count", done_cnt_5, 1);
      chk("exp_5_empty", exp_5.size(), 0);

      // Full 00..FF sweep of fixed points, with a stalled record and a stray start
      for (int i = 0; i < 256; i++) exp_a.push_back(rec_t'{i[7:0], 1'b0, i[7:0], 9'd1, 9'd0});
      pulse_a();
      for (int i = 0; i < 200 && hs_a < 3; i++) @(negedge clk);
      @(posedge clk); #1 rdy_a = 1'b0;
      for (int i = 0; i < 50 && !vld_a; i++) @(negedge clk);
      chk("stall_valid", vld_a, 1);
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      repeat (8) @(posedge clk);
      #1 rdy_a = 1'b1;
      for (int i = 0; i < 3000 && done_cnt_a == 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("sweep_done_count", done_cnt_a, 1);
      chk("sweep_records", hs_a, 256);
      chk("sweep_exp_empty", exp_a.size(), 0);
      chk("idle_busy", busy_a, 0);

      // Increment map: one 256-long cycle, then abort mid-TRACK of init 01
      map_sel = 2'd1;
      hs_base = hs_a;
      exp_a.push_back(rec_t'{8'h00, 1'b1, 8'h00, 9'd256, 9'd0});
      pulse_a();
      for (int i = 0; i < 600 && hs_a == hs_base; i++) @(negedge clk);
      chk("incr_record_seen", hs_a - hs_base, 1);
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      repeat (30) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("reset_mid_track", {init_a, load_a, vld_a, rinit_a, rtype_a, rstate_a, rlen_a,
                              rtrans_a, busy_a, done_a}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_after_abort", {busy_a, vld_a, load_a}, 0);
      chk("no_partial_record", hs_a - hs_base, 1);

      // Custom map: cycle 4-5-6-7 entered after one transient step
      map_sel = 2'd2;
      hs_base = hs_a;
      exp_a.push_back(rec_t'{8'h00, 1'b1, 8'h05, 9'd4, 9'd1});
      exp_a.push_back(rec_t'{8'h01, 1'b1, 8'h06, 9'd4, 9'd1});
      exp_a.push_back(rec_t'{8'h02, 1'b1, 8'h07, 9'd4, 9'd1});
      pulse_a();
      for (int i = 0; i < 200 && (hs_a - hs_base) < 3; i++) @(negedge clk);
      chk("custom_records", hs_a - hs_base, 3);
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("final_exp_empty", exp_a.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
